tx_word_unpacker: RTL
=====================

Name: tx_word_unpacker

Overview:
- Sits between the Crypter output and UART_TX.
- Accepts one multi-byte word (default 32 bits) from the Crypter and feeds it to the transmitter one byte at a time, MSB first.
- For each byte: one-cycle tx_start pulse with tx_data, then wait for UART_TX's tx_done_tick before issuing the next byte.
- Provides a busy flag and an end-of-word pulse so upstream logic knows when the next word may be presented.

Parameters:
- BYTES, 4, number of bytes per word; legal range 2..8.
- DATA_W, 8*BYTES, word width; derived, not to be overridden.
- CNT_W, $clog2(BYTES), byte counter width.

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- word_in  in  DATA_W  word to transmit; sampled only on accept
- word_valid  in  1  Crypter presents word_in
- word_ready  out  1  high only in IDLE; accept = word_valid & word_ready
- tx_data  out  8  byte to UART_TX; held stable from tx_start until the matching tx_done_tick
- tx_start  out  1  one-cycle pulse: start transmitting tx_data
- tx_done_tick  in  1  one-cycle pulse from UART_TX: byte sent
- busy  out  1  high from accept until the final byte's tx_done_tick (inclusive)
- word_done  out  1  one-cycle pulse in the cycle after the final tx_done_tick

Behaviour:
- Reset values:
  - state = IDLE; shift register, byte counter and tx_data = 0.
  - tx_start, busy, word_done = 0; word_ready = 1 in the first cycle after reset.
- FSM states: IDLE, START, WAIT.
- IDLE:
  - word_ready = 1.
  - On accept at edge N: latch word_in into the shift register, clear the counter, go to START.
  - tx_done_tick is ignored.
- START (one cycle):
  - tx_start = 1; tx_data = shift_reg[DATA_W-1 -: 8]; busy = 1.
  - Go to WAIT unconditionally.
- WAIT:
  - busy = 1; tx_start = 0; tx_data held.
  - On tx_done_tick:
    - If counter == BYTES-1, go to IDLE and assert word_done next cycle.
    - Otherwise shift register <<= 8, counter += 1, go to START.
  - Without tx_done_tick: remain in WAIT indefinitely; no timeout.
- Latency:
  - Accept at edge N gives tx_start high in cycle N+1.
  - tx_done_tick at cycle M gives the next tx_start at cycle M+1.
  - Final tx_done_tick at M gives word_done = 1 and word_ready = 1 at M+1.
- Minimum idle gap: a word presented in the same cycle as the final tx_done_tick is not accepted; it is accepted in cycle M+1 if word_valid is still high. Upstream holds word_valid until accepted.
- A tx_done_tick arriving in START (same cycle as tx_start) is ignored. UART_TX cannot legally produce it.
- word_valid while busy: ignored; word_in changes while busy have no effect on transmission.
- Counter: CNT_W bits and never wraps. The exit condition is an equality compare with BYTES-1.
- tx_data is registered (no combinational path from word_in).
- busy must equal the UART TX flag semantics: set on accept, cleared after the last byte.
- Reset mid-operation (any state):
  - Next cycle: IDLE, tx_start = 0, busy = 0, word_done = 0.
  - The partial word is discarded; a late tx_done_tick after reset is ignored.

Decomposition:
- Shared package holds:
  - localparams for state encoding (IDLE = 2'd0, START = 2'd1, WAIT = 2'd2);
  - the BYTE_W = 8 constant.
- Single module; no sub-module needed.
- The shift register and counter stay inline, in the same two-process (registered state + combinational next-state) style as the other UART interfaces.

Test Plan:
- Reset then idle:
  - Stimulus: rst high 3 cycles, then low.
  - Required: word_ready = 1, busy = 0, tx_start = 0, tx_data = 8'h00.
- Nominal word:
  - Stimulus: word_in = 32'hDEADBEEF with word_valid for 1 cycle; bench UART model answers tx_done_tick 10 cycles after each tx_start.
  - Required: exactly 4 tx_start pulses with tx_data DE, AD, BE, EF in order; word_done once, 1 cycle after the 4th done tick; busy high throughout.
- Back-to-back words:
  - Stimulus: hold word_valid with 32'h01020304, switching to 32'hA0B0C0D0 right after the first accept.
  - Required: second accept exactly 1 cycle after the first word's final tx_done_tick; bytes 01 02 03 04 A0 B0 C0 D0.
- Spurious inputs:
  - Stimulus: tx_done_tick pulses in IDLE; word_valid toggling with 32'hFFFFFFFF mid-word.
  - Required: no tx_start in IDLE; the in-flight word's bytes are unchanged; no extra accept.
- Reset mid-word:
  - Stimulus: assert rst after the 2nd tx_start of 32'h11223344, then send one late tx_done_tick.
  - Required: IDLE next cycle, no further tx_start, no word_done; a subsequent 32'h55667788 transmits correctly.
- Stall:
  - Stimulus: withhold tx_done_tick for 1000 cycles after the 1st byte.
  - Required: tx_data remains 8'h11, busy stays 1, no extra tx_start.

Source files
------------

// File: rtl/tx_word_unpacker_pkg.sv
// Shared constants for the word-to-byte unpacker feeding UART_TX.
// Holds the state encoding and the byte width.
package tx_word_unpacker_pkg;

    localparam int BYTE_W = 8;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        START = ST_START,
        WAIT  = ST_WAIT
    } state_t;

endpackage

// File: rtl/tx_word_unpacker.sv
// Takes one BYTES-wide word and hands it to UART_TX MSB byte first,
// issuing tx_start per byte and waiting for tx_done_tick between bytes.
module tx_word_unpacker
    import tx_word_unpacker_pkg::*;
#(
    parameter int BYTES  = 4,
    parameter int DATA_W = BYTE_W * BYTES,
    parameter int CNT_W  = $clog2(BYTES)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] word_in,
    input  logic              word_valid,
    output logic              word_ready,
    output logic [BYTE_W-1:0] tx_data,
    output logic              tx_start,
    input  logic              tx_done_tick,
    output logic              busy,
    output logic              word_done
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BYTES - 1);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [DATA_W-1:0]   r_shift;
    logic [DATA_W-1:0]   w_shift_nxt;
    logic [CNT_W-1:0]    r_cnt;
    logic [CNT_W-1:0]    w_cnt_nxt;
    logic                r_word_done;
    logic                w_word_done_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_shift     <= '0;
            r_cnt       <= '0;
            r_word_done <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_shift     <= w_shift_nxt;
            r_cnt       <= w_cnt_nxt;
            r_word_done <= w_word_done_nxt;
        end
    end

    // tx_done_tick only matters in WAIT; IDLE and START ignore it.
    always_comb begin
        w_state_nxt     = r_state;
        w_shift_nxt     = r_shift;
        w_cnt_nxt       = r_cnt;
        w_word_done_nxt = 1'b0;
        case (r_state)
            IDLE: begin
                if (word_valid) begin
                    w_shift_nxt = word_in;
                    w_cnt_nxt   = '0;
                    w_state_nxt = START;
                end
            end
            START: w_state_nxt = WAIT;
            WAIT: begin
                if (tx_done_tick) begin
                    if (r_cnt == CNT_LAST) begin
                        w_state_nxt     = IDLE;
                        w_word_done_nxt = 1'b1;
                    end else begin
                        w_shift_nxt = r_shift << BYTE_W;
                        w_cnt_nxt   = r_cnt + 1'b1;
                        w_state_nxt = START;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // The top byte of the shift register is the byte in flight, so tx_data
    // stays put until the shift on the matching tx_done_tick.
    assign tx_data    = r_shift[DATA_W-1 -: BYTE_W];
    assign tx_start   = (r_state == START);
    assign busy       = (r_state != IDLE);
    assign word_ready = (r_state == IDLE);
    assign word_done  = r_word_done;

endmodule
